// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and line-level bit constants,
// used by both the TX and RX controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART transmitter. Counts 0..div_q and wraps;
// bit_end marks the last clock of every bit period. restart pins the count
// to 0 so a new bit period starts on the following cycle.
module uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div_q,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign bit_end = (cnt_q == div_q);

  // Free-running bit-period counter, cleared by restart or at the wrap point.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from a show-ahead FIFO and shifts
// them out LSB first as 8N1 frames with a programmable bit period.
// Optional even/odd parity bit is built in when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty FIFO
// START  | driving the start bit (0)
// DATA   | shifting DATA_WIDTH data bits, LSB first
// PARITY | driving the parity bit (UART_TX_PARITY_EN builds only)
// STOP   | driving the stop bit (1); may chain straight into the next START
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_odd,
`endif
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  pop;
  logic                  restart;
`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`endif

  // A pop is only legal between frames; rst suppresses it so an abandoned
  // frame never consumes a byte.
  assign pop = enable && !fifo_empty && !rst &&
               ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign restart    = pop || (state_q == IDLE);
  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .div_q   (div_q),
    .bit_end (bit_end)
  );

  // Next-state and next-output decode; a pop overrides whatever the state chose.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = sr_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = STOP_BIT;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sr_d      = sr_q >> 1;
            tx_d      = sr_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
          tx_d    = STOP_BIT;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
    endcase

    if (pop) begin
      state_d   = START;
      sr_d      = fifo_dout;
      bit_cnt_d = '0;
      tx_d      = START_BIT;
      busy_d    = 1'b1;
    end
  end

  // State, datapath and registered outputs; divisor is only sampled at a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (pop) begin
        div_q <= baud_div;
`ifdef UART_TX_PARITY_EN
        par_q <= (^fifo_dout) ^ parity_odd;
`endif
      end
    end
  end

endmodule
